// File: rtl/filter_sched.sv
// filter_sched: grants the shared second-difference filter to one of two
// sample requesters for a fixed-length block. It clears the filter history at
// each block start, drives the shift-enable and input mux, and tags results
// as valid or last.
module filter_sched #(
  parameter int unsigned DW    = 128,
  parameter int unsigned BLOCK = 64,
  parameter int unsigned CW    = 6
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          enable,
  input  logic [1:0]    req_valid,
  input  logic [DW-1:0] req_data0,
  input  logic [DW-1:0] req_data1,
  output logic [1:0]    req_ready,
  output logic          f_clr,
  output logic          f_en,
  output logic [DW-1:0] f_data,
  output logic          res_valid,
  output logic          res_ch,
  output logic          res_last,
  output logic          block_done,
  output logic          busy,
  output logic [15:0]   blk_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK - 1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);

  state_t        state;
  logic          rr_ptr;
  logic          grant;
  logic [CW-1:0] cnt;

  logic          xfer;
  logic          pick;
  logic          cnt_last;
  logic          cnt_ge2;

  // Transfer detect, grant choice and the filter input path.
  always_comb begin
    xfer     = |(req_valid & req_ready);
    pick     = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
    cnt_last = (cnt == CNT_LAST);
    cnt_ge2  = (cnt >= CNT_TWO);
    f_en     = xfer;
    f_data   = grant ? req_data1 : req_data0;
  end

  // Block sequencer; every control output is a flop set on the transition
  // into the state that owns it, so nothing reaches the outputs
  // combinationally from the requesters except f_en/f_data.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      grant      <= 1'b0;
      cnt        <= '0;
      req_ready  <= '0;
      f_clr      <= 1'b0;
      res_valid  <= 1'b0;
      res_ch     <= 1'b0;
      res_last   <= 1'b0;
      block_done <= 1'b0;
      busy       <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      f_clr      <= 1'b0;
      block_done <= 1'b0;
      res_valid  <= 1'b0;
      res_last   <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && (|req_valid)) begin
            grant <= pick;
            f_clr <= 1'b1;
            busy  <= 1'b1;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          cnt       <= '0;
          req_ready <= grant ? 2'b10 : 2'b01;
          state     <= RUN;
        end
        RUN: begin
          if (xfer) begin
            cnt       <= cnt + 1'b1;
            res_valid <= cnt_ge2;
            res_last  <= cnt_last;
            res_ch    <= grant;
            if (cnt_last) begin
              req_ready  <= '0;
              block_done <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          blk_cnt <= blk_cnt + 16'd1;
          rr_ptr  <= ~grant;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_sched.sv
// tb_filter_sched: directed checks of the filter sequencer/arbiter with the
// default 64-sample block.
module tb_filter_sched;

  localparam int DW    = 128;
  localparam int BLOCK = 64;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [DW-1:0] req_data0, req_data1;
  logic [1:0]    req_ready;
  logic          f_clr, f_en, res_valid, res_ch, res_last, block_done, busy;
  logic [DW-1:0] f_data;
  logic [15:0]   blk_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // bench-side statistics, gathered on the falling edge
  int seq0, seq1;
  int n_en, n_en_blk, n_res, n_res0, n_res1, n_last, n_done, n_clr, blk_res;
  int data_err, tag_err, blk_err, rdy_err, gap_err, zrun;
  int seen_ready;
  int first_ready;
  int order [8];

  assign req_data0 = {64'hC0C0_C0C0_C0C0_C0C0, 64'(seq0 + 1)};
  assign req_data1 = {64'hC1C1_C1C1_C1C1_C1C1, 64'(seq1 + 1)};

  filter_sched #(.DW(DW), .BLOCK(BLOCK), .CW(6)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .req_valid(req_valid),
    .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
    .f_clr(f_clr), .f_en(f_en), .f_data(f_data), .res_valid(res_valid),
    .res_ch(res_ch), .res_last(res_last), .block_done(block_done),
    .busy(busy), .blk_cnt(blk_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_stats();
    seq0 = 0; seq1 = 0;
    n_en = 0; n_en_blk = 0; n_res = 0; n_res0 = 0; n_res1 = 0; n_last = 0;
    n_done = 0; n_clr = 0; blk_res = 0;
    data_err = 0; tag_err = 0; blk_err = 0; rdy_err = 0; gap_err = 0; zrun = 0;
    seen_ready = 0; first_ready = 0;
    for (int i = 0; i < 8; i++) order[i] = -1;
  endtask

  // Observe every cycle away from the active edge.
  always @(negedge CLK) begin
    if (RST) begin
      if (res_valid) begin
        if (blk_res == 0 && n_en_blk != 3) tag_err++;
        blk_res++;
        n_res++;
        if (res_ch) n_res1++; else n_res0++;
        if (res_last) begin
          n_last++;
          if (n_en_blk != BLOCK) tag_err++;
        end
      end else if (res_last) tag_err++;
      if (f_clr) n_clr++;
      if (block_done) begin
        if (n_done < 8) order[n_done] = int'(res_ch);
        n_done++;
        if (n_en_blk != BLOCK) blk_err++;
        if (blk_res != BLOCK - 2) tag_err++;
        n_en_blk = 0;
        blk_res = 0;
      end
      if ((req_valid & req_ready) != 2'b00) begin
        if (!f_en) data_err++;
        if (req_ready[1]) begin
          if (f_data !== {64'hC1C1_C1C1_C1C1_C1C1, 64'(seq1 + 1)}) data_err++;
          seq1++;
        end else begin
          if (f_data !== {64'hC0C0_C0C0_C0C0_C0C0, 64'(seq0 + 1)}) data_err++;
          seq0++;
        end
      end else if (f_en) data_err++;
      if (f_en) begin
        n_en++;
        n_en_blk++;
      end
      if (req_ready == 2'b11) rdy_err++;
      if (req_ready == 2'b00) zrun++;
      else begin
        if (seen_ready != 0 && zrun > 0 && zrun < 3) gap_err++;
        if (seen_ready == 0) first_ready = int'(req_ready);
        seen_ready = 1;
        zrun = 0;
      end
    end
  end

  task automatic do_reset();
    RST = 1'b0;
    enable = 1'b0;
    req_valid = 2'b00;
    repeat (2) @(negedge CLK);
    check("rst_ready", req_ready, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_fclr", f_clr, 1'b0);
    check("rst_blkcnt", blk_cnt, 16'd0);
    RST = 1'b1;
    clear_stats();
  endtask

  task automatic wait_done(input string tag, input int max);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) begin
      @(negedge CLK);
      if (block_done) hit = 1'b1;
    end
    #1;
    check({tag, "_done_seen"}, hit, 1'b1);
  endtask

  task automatic wait_seq(input string tag, input int ch, input int target, input int max);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) begin
      @(posedge CLK);
      #1;
      if (((ch == 0) ? seq0 : seq1) >= target) hit = 1'b1;
    end
    check({tag, "_seq_seen"}, hit, 1'b1);
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_data_err"}, data_err, 0);
    check({tag, "_tag_err"}, tag_err, 0);
    check({tag, "_blk_err"}, blk_err, 0);
    check({tag, "_rdy_err"}, rdy_err, 0);
    check({tag, "_gap_err"}, gap_err, 0);
  endtask

  initial begin
    int en0;
    clear_stats();

    // single requester, latency and block totals
    do_reset();
    @(posedge CLK); #1;
    enable = 1'b1;
    req_valid = 2'b01;
    @(negedge CLK);
    check("t1_busy_idle", busy, 1'b0);
    @(negedge CLK);
    check("t1_fclr_t1", f_clr, 1'b1);
    check("t1_ready_t1", req_ready, 2'b00);
    check("t1_busy_t1", busy, 1'b1);
    @(negedge CLK);
    check("t1_fclr_t2", f_clr, 1'b0);
    check("t1_ready_t2", req_ready, 2'b01);
    check("t1_fen_t2", f_en, 1'b1);
    wait_done("t1", 200);
    req_valid = 2'b00;
    check("t1_n_en", n_en, 64);
    check("t1_n_res", n_res, 62);
    check("t1_n_res0", n_res0, 62);
    check("t1_n_last", n_last, 1);
    check("t1_n_done", n_done, 1);
    check("t1_n_clr", n_clr, 1);
    repeat (2) @(negedge CLK);
    check("t1_blkcnt", blk_cnt, 16'd1);
    check("t1_busy_end", busy, 1'b0);
    check_errs("t1");

    // contention: alternating grants
    do_reset();
    enable = 1'b1;
    req_valid = 2'b11;
    for (int b = 0; b < 4; b++) wait_done("t2", 200);
    enable = 1'b0;
    req_valid = 2'b00;
    repeat (5) @(negedge CLK);
    check("t2_order0", order[0], 0);
    check("t2_order1", order[1], 1);
    check("t2_order2", order[2], 0);
    check("t2_order3", order[3], 1);
    check("t2_seq0", seq0, 128);
    check("t2_seq1", seq1, 128);
    check("t2_n_res0", n_res0, 124);
    check("t2_n_res1", n_res1, 124);
    check("t2_n_last", n_last, 4);
    check("t2_blkcnt", blk_cnt, 16'd4);
    check_errs("t2");

    // stall on requester 1
    do_reset();
    enable = 1'b1;
    req_valid = 2'b10;
    wait_seq("t3", 1, 10, 100);
    req_valid = 2'b00;
    en0 = n_en;
    repeat (5) @(posedge CLK);
    #1;
    check("t3_busy_gap", busy, 1'b1);
    check("t3_en_gap", n_en, en0);
    check("t3_en_before", en0, 10);
    req_valid = 2'b10;
    wait_done("t3", 200);
    req_valid = 2'b00;
    check("t3_seq1", seq1, 64);
    check("t3_n_res1", n_res1, 62);
    check("t3_n_res0", n_res0, 0);
    check("t3_order0", order[0], 1);
    repeat (2) @(negedge CLK);
    check("t3_blkcnt", blk_cnt, 16'd1);
    check_errs("t3");

    // enable gating
    do_reset();
    req_valid = 2'b11;
    repeat (10) @(negedge CLK);
    check("t4_busy_off", busy, 1'b0);
    check("t4_clr_off", n_clr, 0);
    check("t4_ready_off", req_ready, 2'b00);
    enable = 1'b1;
    wait_seq("t4", 0, 30, 100);
    enable = 1'b0;
    wait_done("t4", 200);
    repeat (10) @(negedge CLK);
    check("t4_n_clr", n_clr, 1);
    check("t4_busy_end", busy, 1'b0);
    check("t4_n_done", n_done, 1);
    check("t4_seq0", seq0, 64);
    check("t4_seq1", seq1, 0);
    check("t4_blkcnt", blk_cnt, 16'd1);
    check_errs("t4");

    // reset in the middle of a channel-1 block
    do_reset();
    enable = 1'b1;
    req_valid = 2'b11;
    wait_done("t5a", 200);
    check("t5_order0", order[0], 0);
    wait_seq("t5", 1, 20, 100);
    check("t5_done_before", n_done, 1);
    check("t5_resch_before", res_ch, 1'b1);
    RST = 1'b0;
    #1;
    check("t5_ready", req_ready, 2'b00);
    check("t5_busy", busy, 1'b0);
    check("t5_fen", f_en, 1'b0);
    check("t5_resv", res_valid, 1'b0);
    check("t5_resch", res_ch, 1'b0);
    check("t5_reslast", res_last, 1'b0);
    check("t5_bdone", block_done, 1'b0);
    check("t5_blkcnt", blk_cnt, 16'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    clear_stats();
    wait_done("t5b", 200);
    check("t5_first_ready", first_ready, 1);
    check("t5_n_clr", n_clr, 1);
    check("t5_order_after", order[0], 0);
    check("t5_n_en", n_en, 64);
    enable = 1'b0;
    req_valid = 2'b00;
    repeat (2) @(negedge CLK);
    check("t5_blkcnt_after", blk_cnt, 16'd1);
    check_errs("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/filter_sched.md
Name: filter_sched

Overview:
Sequencer and arbiter for the shared 128-bit second-difference filter datapath (y = x1 - 2*x2 + x3). It grants the single filter to one of two sample requesters for a fixed-length block and clears the filter history at each block start. It drives the datapath shift-enable and input mux, and tags filter results as valid or last. It sits between the sample sources and the filter/averaging datapath.

Parameters:
DW, 128, sample word width
BLOCK, 64, samples per granted block (power of 2, >= 4)
CW, 6, block counter width = log2(BLOCK)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous active-low reset
enable  in  1  allows new grants; sampled only in IDLE
req_valid  in  2  per-requester sample valid
req_data0  in  DW  requester 0 sample
req_data1  in  DW  requester 1 sample
req_ready  out  2  per-requester ready, one-hot or zero
f_clr  out  1  one-cycle clear of filter history (V1..V3) and average buffer
f_en  out  1  shift-enable to filter; high exactly on accepted transfer
f_data  out  DW  sample to filter (granted requester's data)
res_valid  out  1  filter output valid, one cycle after f_en
res_ch  out  1  channel owning current result
res_last  out  1  with res_valid, final result of block
block_done  out  1  one-cycle pulse, block finished
busy  out  1  state != IDLE
blk_cnt  out  16  completed blocks, wraps at 65535 -> 0

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; rr_ptr=0 (channel 0 preferred); cnt=0; grant=0. All outputs are 0, except f_data, which is a don't-care that the bench must not check.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE: if enable && |req_valid, register grant and go to CLEAR.
  - Grant rule: if only one requester is valid, grant it. If both are valid, grant the channel equal to rr_ptr.
- CLEAR: f_clr=1 for exactly one cycle; cnt<=0; go to RUN.
- RUN: req_ready[grant]=1, other bit 0.
  - Transfer = req_valid[grant] && req_ready[grant].
  - On transfer: f_en=1, f_data=req_data[grant] (combinational mux), cnt<=cnt+1.
  - Without transfer, stay in RUN with no timeout. The other requester is ignored even if valid.
  - The transfer with cnt==BLOCK-1 goes to DONE.
- DONE: block_done=1 for one cycle; blk_cnt<=blk_cnt+1; rr_ptr<=~grant; go to IDLE.
- enable deassertion outside IDLE has no effect; the current block always completes.
- Grant latency: request seen in IDLE at cycle t -> f_clr at t+1 -> req_ready at t+2. Minimum block occupancy is BLOCK+3 cycles.
- Result tagging, registered one cycle after f_en:
  - res_valid=1 only when the transfer's cnt >= 2, i.e. the filter holds 3 fresh samples. The first two transfers of each block produce no result.
  - res_last=1 with the result of the cnt==BLOCK-1 transfer.
  - res_ch = grant of that transfer.
  - Results per block = BLOCK-2.
- Back-to-back blocks: DONE -> IDLE -> CLEAR. A requester always sees at least 3 cycles of ready=0 between blocks.
- Reset mid-block: immediate return to reset state. Partial results are dropped and no block_done is emitted.
- Counter arithmetic: cnt is CW bits and never wraps inside RUN. blk_cnt is 16 bits, modulo 2^16.

Test Plan:
- Single requester: reset, enable=1, req_valid=01 held, data 1,2,3..64 -> f_clr at t+1, ready at t+2, 64 f_en pulses, 62 res_valid with res_ch=0, res_last on 64th, block_done once, blk_cnt=1.
- Contention: both valid continuously from reset -> blocks granted 0,1,0,1; each block exactly 64 transfers; other ready stays 0 throughout.
- Stall: requester 1 alone, drop valid for 5 cycles after sample 10 -> busy stays 1, no f_en during gap, cnt resumes; totals still 64/62.
- Enable gating: enable=0 with req_valid=11 -> stays IDLE, busy=0. Drop enable at sample 30 of a block -> block completes, no new grant afterwards.
- Reset mid-block: assert RST at sample 20 -> all outputs 0 asynchronously, blk_cnt=0, next grant to channel 0, with f_clr issued again.
- Wrap: preload via 65536 short blocks (BLOCK=4 build) -> blk_cnt returns to 0; results per block = 2.
